// File: rtl/muldiv_pkg.sv
// Shared types and decode constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_WRITE = 2'd2
    } md_state_e;

    localparam int unsigned IDX_DIV   = 32'd31;
    localparam int unsigned IDX_DIVU  = 32'd32;
    localparam int unsigned IDX_MULT  = 32'd33;
    localparam int unsigned IDX_MULTU = 32'd34;
    localparam int unsigned IDX_MFHI  = 32'd35;
    localparam int unsigned IDX_MFLO  = 32'd36;
    localparam int unsigned IDX_MTHI  = 32'd37;
    localparam int unsigned IDX_MTLO  = 32'd38;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] MF_NORMAL = 2'b00;
    localparam logic [1:0] MF_HI     = 2'b01;
    localparam logic [1:0] MF_LO     = 2'b10;

    function automatic logic [1:0] op_encode(input logic div, input logic divu,
                                             input logic multu);
        logic [1:0] op;
        if (divu) begin
            op = OP_DIVU;
        end else if (div) begin
            op = OP_DIV;
        end else if (multu) begin
            op = OP_MULTU;
        end else begin
            op = OP_MULT;
        end
        return op;
    endfunction

endpackage

// File: rtl/muldiv_lat_counter.sv
// Loadable down-counter that tracks remaining iterative-unit latency.
module muldiv_lat_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative multiply/divide unit and HI/LO writes, stalling
// the PC while an operation is in flight.
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [53:0] RESULT,
    input  logic        DIV_ZERO,
    output logic        PC_EN,
    output logic        MD_START,
    output logic [1:0]  MD_OP,
    output logic        MD_BUSY,
    output logic        HI_W,
    output logic        LO_W,
    output logic        HILO_SRC,
    output logic [1:0]  MF_SEL
);

    md_state_e        state_q;
    logic             md_start_q;
    logic [1:0]       md_op_q;
    logic             dz_q;

    logic             md_req_s;
    logic             is_div_s;
    logic             dz_now_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             unused_result_s;

    assign is_div_s = RESULT[IDX_DIV] | RESULT[IDX_DIVU];
    assign md_req_s = is_div_s | RESULT[IDX_MULT] | RESULT[IDX_MULTU];
    assign dz_now_s = DIV_ZERO & is_div_s;
    assign unused_result_s = ^{RESULT[53:39], RESULT[30:0]};

    // Counter holds LAT-1 on entry to BUSY so BUSY lasts exactly LAT cycles.
    assign cnt_load_val_s = is_div_s ? CNT_W'(DIV_LAT - 32'd1) : CNT_W'(MUL_LAT - 32'd1);
    assign cnt_load_s     = (state_q == ST_IDLE) && md_req_s && !dz_now_s;
    assign cnt_dec_s      = (state_q == ST_BUSY) && !cnt_zero_s;

    muldiv_lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Sequencer state, latched op, div-zero flag and start pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            md_start_q <= 1'b0;
            md_op_q    <= OP_MULT;
            dz_q       <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (md_req_s) begin
                        md_op_q <= op_encode(RESULT[IDX_DIV], RESULT[IDX_DIVU],
                                             RESULT[IDX_MULTU]);
                        dz_q    <= dz_now_s;
                        if (dz_now_s) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q    <= ST_BUSY;
                            md_start_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_zero_s) begin
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_WRITE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode; in IDLE a mul/div request outranks MT*/MF*.
    always_comb begin
        PC_EN    = 1'b1;
        HI_W     = 1'b0;
        LO_W     = 1'b0;
        HILO_SRC = 1'b0;
        MF_SEL   = MF_NORMAL;
        case (state_q)
            ST_IDLE: begin
                PC_EN = ~md_req_s;
                if (md_req_s) begin
                    MF_SEL = MF_NORMAL;
                end else if (RESULT[IDX_MTHI]) begin
                    HI_W     = 1'b1;
                    HILO_SRC = 1'b1;
                end else if (RESULT[IDX_MTLO]) begin
                    LO_W     = 1'b1;
                    HILO_SRC = 1'b1;
                end else if (RESULT[IDX_MFHI]) begin
                    MF_SEL = MF_HI;
                end else if (RESULT[IDX_MFLO]) begin
                    MF_SEL = MF_LO;
                end else begin
                    MF_SEL = MF_NORMAL;
                end
            end
            ST_BUSY: begin
                PC_EN = 1'b0;
            end
            ST_WRITE: begin
                HI_W = ~dz_q;
                LO_W = ~dz_q;
            end
            default: begin
                PC_EN = 1'b1;
            end
        endcase
    end

    assign MD_START = md_start_q;
    assign MD_OP    = md_op_q;
    assign MD_BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: retire and start events are
// predicted at issue and matched when the DUT produces them.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        CLK;
    logic        RST_N;
    logic [53:0] RESULT;
    logic        DIV_ZERO;
    logic        PC_EN, MD_START, MD_BUSY, HI_W, LO_W, HILO_SRC;
    logic [1:0]  MD_OP, MF_SEL;

    muldiv_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .CLK(CLK), .RST_N(RST_N), .RESULT(RESULT), .DIV_ZERO(DIV_ZERO),
        .PC_EN(PC_EN), .MD_START(MD_START), .MD_OP(MD_OP), .MD_BUSY(MD_BUSY),
        .HI_W(HI_W), .LO_W(LO_W), .HILO_SRC(HILO_SRC), .MF_SEL(MF_SEL)
    );

    typedef struct {
        int         cyc;
        logic [1:0] op;
        logic       wen;
    } exp_t;

    exp_t sb[$];
    int   start_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_starts = 0;
    int   exp_starts = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [53:0] onehot(input int idx);
        logic [53:0] v;
        v = 54'd0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: match start pulses and retirements against predictions.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (MD_START) begin
                n_starts++;
                if (start_q.size() == 0) chk("start_unexpected", start_q.size(), 1);
                else chk("start_cycle", start_q.pop_front(), cyc);
            end
            if (MD_BUSY && PC_EN) begin
                if (sb.size() == 0) begin
                    chk("retire_unexpected", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("retire_cycle", cyc, e.cyc);
                    chk("md_op", MD_OP, e.op);
                    chk("hi_w", HI_W, e.wen);
                    chk("lo_w", LO_W, e.wen);
                    chk("hilo_src_wr", HILO_SRC, 1'b0);
                end
            end
        end
    end

    task automatic md_instr(input int idx, input logic dz, input bit toggle);
        int         lat, occ;
        logic       is_div, eff_dz;
        logic [1:0] op;
        exp_t       e;
        is_div = (idx == IDX_DIV) || (idx == IDX_DIVU);
        eff_dz = dz && is_div;
        lat = is_div ? DIV_LAT : MUL_LAT;
        occ = eff_dz ? 2 : lat + 2;
        op  = (idx == IDX_MULT) ? OP_MULT : (idx == IDX_MULTU) ? OP_MULTU :
              (idx == IDX_DIV)  ? OP_DIV  : OP_DIVU;
        RESULT   = onehot(idx);
        DIV_ZERO = dz;
        e.cyc = cyc + occ - 1;
        e.op  = op;
        e.wen = ~eff_dz;
        sb.push_back(e);
        if (!eff_dz) begin
            start_q.push_back(cyc + 1);
            exp_starts++;
        end
        for (int k = 0; k < occ; k++) begin
            @(negedge CLK);
            chk("pc_en", PC_EN, (k == occ - 1));
            chk("md_busy", MD_BUSY, (k != 0));
            step();
            if (toggle && k < occ - 2) begin
                RESULT   = onehot(31 + $urandom_range(7, 0));
                DIV_ZERO = 1'($urandom_range(1, 0));
            end else begin
                RESULT   = onehot(idx);
                DIV_ZERO = dz;
            end
        end
        RESULT   = 54'd0;
        DIV_ZERO = 1'b0;
    endtask

    task automatic single(input int idx, input logic hw, input logic lw,
                          input logic src, input logic [1:0] mf);
        RESULT = onehot(idx);
        @(negedge CLK);
        chk("s_pc_en", PC_EN, 1'b1);
        chk("s_hi_w", HI_W, hw);
        chk("s_lo_w", LO_W, lw);
        chk("s_hilo_src", HILO_SRC, src);
        chk("s_mf_sel", MF_SEL, mf);
        chk("s_busy", MD_BUSY, 1'b0);
        step();
    endtask

    initial begin
        RST_N = 1'b0;
        RESULT = 54'd0;
        DIV_ZERO = 1'b0;
        step(); step(); step();
        @(negedge CLK);
        chk("rst_pc_en", PC_EN, 1'b1);
        chk("rst_busy", MD_BUSY, 1'b0);
        chk("rst_start", MD_START, 1'b0);
        chk("rst_md_op", MD_OP, OP_MULT);
        chk("rst_hi_w", HI_W, 1'b0);
        chk("rst_lo_w", LO_W, 1'b0);
        step();
        RST_N = 1'b1;
        step();

        md_instr(IDX_MULT, 1'b0, 1'b0);
        md_instr(IDX_DIVU, 1'b0, 1'b1);
        md_instr(IDX_DIV, 1'b1, 1'b0);
        md_instr(IDX_DIVU, 1'b1, 1'b0);
        md_instr(IDX_MULT, 1'b1, 1'b0);

        single(IDX_MTHI, 1'b1, 1'b0, 1'b1, MF_NORMAL);
        single(IDX_MTLO, 1'b0, 1'b1, 1'b1, MF_NORMAL);
        single(IDX_MFHI, 1'b0, 1'b0, 1'b0, MF_HI);
        single(IDX_MFLO, 1'b0, 1'b0, 1'b0, MF_LO);
        RESULT = 54'd0;

        md_instr(IDX_MULT, 1'b0, 1'b0);
        md_instr(IDX_MULTU, 1'b0, 1'b1);
        md_instr(IDX_DIV, 1'b0, 1'b0);
        step();

        // Abort a MULT mid-BUSY; no retirement is predicted for it.
        RESULT = onehot(IDX_MULT);
        start_q.push_back(cyc + 1);
        exp_starts++;
        step(); step();
        RST_N = 1'b0;
        RESULT = 54'd0;
        step();
        step();
        @(negedge CLK);
        chk("abort_pc_en", PC_EN, 1'b1);
        chk("abort_busy", MD_BUSY, 1'b0);
        chk("abort_start", MD_START, 1'b0);
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("post_abort_hi_w", HI_W, 1'b0);
            chk("post_abort_lo_w", LO_W, 1'b0);
            chk("post_abort_busy", MD_BUSY, 1'b0);
            step();
        end

        chk("sb_empty", sb.size(), 0);
        chk("start_q_empty", start_q.size(), 0);
        chk("start_count", n_starts, exp_starts);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the iterative multiply/divide unit and HI/LO register pair in the single-cycle MIPS core.
- Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the one-hot instruction vector.
- Stalls the PC while the iterative unit runs, pulses its start signal and issues HI/LO write enables on completion.
- Sits beside the existing control unit, sharing the same 54-bit one-hot decode bus.

Parameters:
- MUL_LAT, 4: cycles the multiplier needs after MD_START; must be ≥1.
- DIV_LAT, 32: cycles the divider needs after MD_START; must be ≥1.
- CNT_W, 6: latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- RESULT  in  54  one-hot decode: [31]DIV [32]DIVU [33]MULT [34]MULTU [35]MFHI [36]MFLO [37]MTHI [38]MTLO.
- DIV_ZERO  in  1  rt operand == 0; sampled only in IDLE.
- PC_EN  out  1  PC/instruction advance enable; 0 = hold current instruction.
- MD_START  out  1  registered one-cycle start pulse to the iterative unit.
- MD_OP  out  2  latched op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- MD_BUSY  out  1  high whenever state != IDLE.
- HI_W  out  1  HI register write enable.
- LO_W  out  1  LO register write enable.
- HILO_SRC  out  1  HI/LO write data select: 0 = mul/div result, 1 = GPR rs (MTHI/MTLO).
- MF_SEL  out  2  register-file write-back select: 00 normal, 01 HI, 10 LO.

Behaviour:
- Reset (RST_N=0 at a rising edge): state=IDLE, counter=0, MD_START=0, MD_OP=00, div-zero flag=0.
- Reset output values: PC_EN=1; HI_W=LO_W=MD_BUSY=0; MF_SEL and HILO_SRC follow the combinational IDLE decode.
- Reset mid-operation aborts with no HI/LO write; the iterative unit result is discarded.
- md_req = RESULT[31]|[32]|[33]|[34].
- Define states IDLE, BUSY and WRITE as an enum.

IDLE:
- PC_EN = ~md_req.
- MTHI: HI_W=1, HILO_SRC=1. MTLO: LO_W=1, HILO_SRC=1. Both take a single cycle with no stall.
- MFHI: MF_SEL=01. MFLO: MF_SEL=10. Both take a single cycle.
- On md_req, latch MD_OP and the div-zero flag = DIV_ZERO & (DIV|DIVU).
- If div-zero: next state is WRITE.
- Otherwise: next state is BUSY, counter = LAT-1 (MUL_LAT or DIV_LAT by op), and MD_START=1 for the next cycle only.

BUSY:
- PC_EN=0, MD_START=0 after its first cycle. RESULT is ignored; the latched op governs.
- Counter decrements each cycle; when counter==0, next state is WRITE.

WRITE:
- HI_W=LO_W=~div-zero flag, HILO_SRC=0, PC_EN=1 so the instruction retires. Next state is IDLE.
- An instruction issued at T0 occupies LAT+2 cycles: PC advances at the edge ending cycle T0+LAT+1.
- Div-by-zero occupies 2 cycles, never asserts MD_START, and leaves HI/LO unchanged.

Other rules:
- Back-to-back mul/div: WRITE returns to IDLE, the next instruction is seen in IDLE and restarts. There is no overlap.
- MFHI directly after MULT reads the freshly written value: HI/LO update at the edge ending WRITE.
- Non-one-hot RESULT is illegal. Priority for determinism: md_req beats MT*/MF*.

Decomposition:
- Package muldiv_pkg: state enum (IDLE, BUSY, WRITE), RESULT bit-index constants 31–38, MD_OP encodings, MF_SEL encodings.
- Sub-module muldiv_lat_counter: loadable CNT_W down-counter with a zero flag. The FSM and output decode stay in the top.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles mid-BUSY -> PC_EN=1, MD_BUSY=0, MD_START=0, no HI_W/LO_W asserted afterwards.
- MULT with MUL_LAT=4, RESULT[33]=1 at T0 -> PC_EN=0 at T0–T4, MD_START=1 only at T1, MD_OP=00, HI_W=LO_W=PC_EN=1 at T5, IDLE at T6.
- DIVU with DIV_LAT=32, DIV_ZERO=0 -> MD_OP=11, stall of 33 cycles, write at T33. Toggle RESULT during BUSY -> no effect.
- DIV with DIV_ZERO=1 -> MD_START never high, WRITE at T1 with HI_W=LO_W=0, PC_EN=1 at T1.
- MTHI, MTLO, MFHI, MFLO in consecutive cycles -> HI_W/HILO_SRC=1, then LO_W/HILO_SRC=1, then MF_SEL=01, then MF_SEL=10. PC_EN=1 throughout.
- MULT directly followed by MULTU -> two full LAT+2 sequences with a single IDLE cycle between; MD_START pulses exactly twice.
